uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 8N1-style framing with a configurable
// number of data bits, LSB first, one stop bit.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   rx_i         serial line (asynchronous, idle high)
//   data_o       last accepted byte, stable while valid_o is high
//   valid_o      data_o holds a byte not yet taken by the consumer
//   ready_i      consumer takes data_o when valid_o && ready_i
//   busy_o       receiver is inside a frame (FSM not in IDLE)
//   frame_err_o  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    one-cycle pulse: completed byte dropped, previous unread
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling data bits at mid-bit, LSB first
// STOP  | sampling the stop bit at mid-bit
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 104
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_d;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  at_full;
  logic                  at_half;
  logic                  done;
  logic                  stop_bad;

  // Synchronizer and edge-detect history reset to the idle level so that
  // reset release on an idle line never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign at_full  = (cnt == CNT_FULL);
  assign at_half  = (cnt == CNT_HALF);
  assign done     = (state == STOP) && at_full && rx_s;
  assign stop_bad = (state == STOP) && at_full && !rx_s;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_d && !rx_s) state_nxt = START;
      // A start bit that is high again at mid-bit was a glitch.
      START: if (at_half) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (at_full && (idx == IDX_LAST)) state_nxt = STOP;
      STOP:  if (at_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;

      // Counter restarts on every state change so each phase times from
      // its own entry point.
      if (state_nxt != state || state == IDLE || at_full)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == START && at_half)
        idx <= '0;
      else if (state == DATA && at_full)
        idx <= idx + 1'b1;

      if (state == DATA && at_full)
        shift <= {rx_s, shift[DATA_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_bad;
      overrun_o   <= 1'b0;
      if (done) begin
        // A handshake in the completion cycle frees the slot for the new byte.
        if (!valid_o || ready_i) begin
          data_o  <= shift;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at default parameters.
// Drives whole frames bit-by-bit and checks outputs with immediate assertions.
module tb_uart_rx;

  localparam int BAUD = 104;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // pulse / event monitors (sampled on the falling edge)
  int         vcyc = 0;
  int         vrise = 0;
  int         fe_n = 0;
  int         ov_n = 0;
  int         fe_run = 0;
  int         fe_max = 0;
  int         ov_run = 0;
  int         ov_max = 0;
  logic       vprev = 1'b0;
  logic [7:0] rq[$];

  int vc0, vr0, fe0, ov0;

  uart_rx #(.DATA_WIDTH(8), .BAUD_DIV(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .ready_i     (ready),
    .data_o      (data),
    .valid_o     (valid),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) vcyc = vcyc + 1;
    if (valid && !vprev) begin
      vrise = vrise + 1;
      rq.push_back(data);
    end
    vprev = valid;
    if (frame_err) begin
      fe_n = fe_n + 1;
      fe_run = fe_run + 1;
      if (fe_run > fe_max) fe_max = fe_run;
    end else begin
      fe_run = 0;
    end
    if (overrun) begin
      ov_n = ov_n + 1;
      ov_run = ov_run + 1;
      if (ov_run > ov_max) ov_max = ov_run;
    end else begin
      ov_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic snap();
    vc0 = vcyc;
    vr0 = vrise;
    fe0 = fe_n;
    ov0 = ov_n;
  endtask

  initial begin
    rx    = 1'b1;
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", busy, 0);

    // single clean frame
    snap();
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    chk("a5_rises", vrise - vr0, 1);
    chk("a5_vcycles", vcyc - vc0, 1);
    chk("a5_data", rq[rq.size()-1], 8'hA5);
    chk("a5_ferr", fe_n - fe0, 0);
    chk("a5_ovr", ov_n - ov0, 0);
    chk("a5_busy", busy, 0);

    // 30-cycle glitch on the line
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (29) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    repeat (100) @(negedge clk);
    chk("glitch_valid", vrise - vr0, 0);
    chk("glitch_ferr", fe_n - fe0, 0);

    // framing error then a held-low line
    snap();
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    chk("ferr_no_retrig", busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_count", fe_n - fe0, 1);
    chk("ferr_valid", vrise - vr0, 0);
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_ferr_rises", vrise - vr0, 1);
    chk("after_ferr_data", rq[rq.size()-1], 8'h55);
    chk("after_ferr_fecnt", fe_n - fe0, 1);

    // overrun with consumer stalled
    snap();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovr_valid1", valid, 1);
    chk("ovr_data1", data, 8'h11);
    send_frame(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovr_pulse", ov_n - ov0, 1);
    chk("ovr_valid2", valid, 1);
    chk("ovr_data2", data, 8'h11);
    ready = 1'b1;
    @(negedge clk);
    chk("ovr_cleared", valid, 0);
    chk("ovr_data_kept", data, 8'h11);
    repeat (5) @(negedge clk);

    // reset during bit 3 of an all-ones frame
    snap();
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD + BAUD / 2) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_data", data, 8'h00);
    chk("mrst_ferr", frame_err, 0);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", vrise - vr0, 0);
    chk("abort_ferr", fe_n - fe0, 0);
    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    chk("post_rst_data", rq[rq.size()-1], 8'h0F);
    chk("post_rst_dout", data, 8'h0F);

    // back-to-back frames
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    chk("b2b_rises", vrise - vr0, 2);
    chk("b2b_vcycles", vcyc - vc0, 2);
    chk("b2b_first", rq[rq.size()-2], 8'h00);
    chk("b2b_second", rq[rq.size()-1], 8'hFF);
    chk("b2b_ferr", fe_n - fe0, 0);
    chk("b2b_ovr", ov_n - ov0, 0);

    chk("ferr_pulse_width", fe_max, 1);
    chk("ovr_pulse_width", ov_max, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
